eth_rx_decap: RTL



---
 rtl/eth_rx_decap.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/eth_rx_decap.sv
// NetTLP receive decapsulation: validates the Ethernet/IPv4/UDP/NetTLP header and forwards the TLP payload.
// Statistics counters are present only when ETH_RX_DECAP_STATS_EN is defined.
module eth_rx_decap #(
   parameter int unsigned CHECK_MAC = 1,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 eth_clk,
   input  logic                 eth_rst,
   input  logic                 eth_rx_tvalid,
   input  logic [63:0]          eth_rx_tdata,
   input  logic [7:0]           eth_rx_tkeep,
   input  logic                 eth_rx_tlast,
   input  logic                 eth_rx_tuser,
   input  logic [47:0]          adapter_reg_srcmac,
   input  logic [31:0]          adapter_reg_srcip,
   input  logic [15:0]          adapter_reg_srcport,
   output logic                 decap_tvalid,
   output logic [63:0]          decap_tdata,
   output logic [7:0]           decap_tkeep,
   output logic                 decap_tlast,
   output logic                 decap_tuser,
   output logic [15:0]          decap_seq,
   output logic [CNT_WIDTH-1:0] stat_pass,
   output logic [CNT_WIDTH-1:0] stat_drop
);
   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] LAST_HDR = CW'(5);

   typedef enum logic [2:0] {SYNC, IDLE, HDR, PAYLOAD, DROP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] beat_idx;
   logic [7:0]    rx_b [8];
   logic          hdr_ok;
   logic          fwd_d;
   logic [15:0]   seq_d;

   always_comb begin
      for (int i = 0; i < 8; i++) rx_b[i] = eth_rx_tdata[8*i +: 8];
   end

   // In IDLE the incoming beat is always header beat 0.
   assign beat_idx = (state_q == HDR) ? cnt_q : '0;

   // Per-beat header field checks against the adapter registers of this cycle.
   always_comb begin
      hdr_ok = 1'b1;
      case (beat_idx)
         3'd0: hdr_ok = (CHECK_MAC == 0) ||
                        ({rx_b[0], rx_b[1], rx_b[2], rx_b[3], rx_b[4], rx_b[5]} == adapter_reg_srcmac);
         3'd1: hdr_ok = ({rx_b[4], rx_b[5]} == 16'h0800) && (rx_b[6] == 8'h45);
         3'd2: hdr_ok = (rx_b[7] == 8'h11);
         3'd3: hdr_ok = ({rx_b[6], rx_b[7]} == adapter_reg_srcip[31:16]);
         3'd4: hdr_ok = ({rx_b[0], rx_b[1]} == adapter_reg_srcip[15:0]) &&
                        ({rx_b[4], rx_b[5]} == adapter_reg_srcport);
         default: hdr_ok = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fwd_d   = 1'b0;
      seq_d   = decap_seq;
      case (state_q)
         SYNC: begin
            if (eth_rx_tvalid && eth_rx_tlast) state_d = IDLE;
         end
         IDLE, HDR: begin
            if (eth_rx_tvalid) begin
               // A header beat carrying tlast is a runt and is dropped like a failed check.
               if (!hdr_ok || eth_rx_tlast) begin
                  cnt_d   = '0;
                  state_d = eth_rx_tlast ? IDLE : DROP;
               end else if (beat_idx == LAST_HDR) begin
                  cnt_d   = '0;
                  state_d = PAYLOAD;
                  seq_d   = {rx_b[2], rx_b[3]};
               end else begin
                  cnt_d   = beat_idx + CW'(1);
                  state_d = HDR;
               end
            end
         end
         PAYLOAD: begin
            if (eth_rx_tvalid) begin
               fwd_d = 1'b1;
               if (eth_rx_tlast) state_d = IDLE;
            end
         end
         DROP: begin
            if (eth_rx_tvalid && eth_rx_tlast) state_d = IDLE;
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) begin
         state_q <= SYNC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Payload path: one-cycle registered copy of the forwarded beat.
   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) begin
         decap_tvalid <= 1'b0;
         decap_tdata  <= '0;
         decap_tkeep  <= '0;
         decap_tlast  <= 1'b0;
         decap_tuser  <= 1'b0;
         decap_seq    <= '0;
      end else begin
         decap_tvalid <= fwd_d;
         decap_tlast  <= fwd_d & eth_rx_tlast;
         decap_tuser  <= fwd_d & eth_rx_tlast & eth_rx_tuser;
         decap_seq    <= seq_d;
         if (fwd_d) begin
            decap_tdata <= eth_rx_tdata;
            decap_tkeep <= eth_rx_tkeep;
         end
      end
   end

`ifdef ETH_RX_DECAP_STATS_EN
   logic                 pass_inc, drop_inc;
   logic [CNT_WIDTH-1:0] pass_q, drop_q;

   assign pass_inc = (state_q == PAYLOAD) && eth_rx_tvalid && eth_rx_tlast;
   assign drop_inc = ((state_q == IDLE) || (state_q == HDR)) && eth_rx_tvalid &&
                     (!hdr_ok || eth_rx_tlast);

   // Saturating frame counters.
   always_ff @(posedge eth_clk or posedge eth_rst) begin
      if (eth_rst) begin
         pass_q <= '0;
         drop_q <= '0;
      end else begin
         if (pass_inc && (pass_q != '1)) pass_q <= pass_q + CNT_WIDTH'(1);
         if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_WIDTH'(1);
      end
   end

   assign stat_pass = pass_q;
   assign stat_drop = drop_q;
`else
   assign stat_pass = '0;
   assign stat_drop = '0;
`endif

endmodule
